skew_stager: RTL and testbench

//  Parametrised diagonal skew stager feeding the systolic-array edge.

---
 rtl/skew_stager_if.sv | 28 ++
 rtl/skew_stager.sv | 136 +++++++++++++
 tb/tb_skew_stager.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skew_stager_if.sv
// skew_stager_if: valid/ready bundle for both sides of the skew stager.
// master = producer/consumer side, slave = the stager itself.
interface skew_stager_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) ();
    localparam int DATA_W = LANES * LANE_W;

    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_last_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_valid_o;
    logic              out_last_o;
    logic              out_ready_i;
    logic              busy_o;

    modport master (
        output in_data_i, in_valid_i, in_last_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, out_last_o, busy_o
    );

    modport slave (
        input  in_data_i, in_valid_i, in_last_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, out_last_o, busy_o
    );
endinterface

// File: rtl/skew_stager.sv
// skew_stager: lane j delayed j beats, self-draining frame tail.
// Optional macro SKEW_BYPASS_EN adds bypass_i for unskewed frames.
module skew_stager #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef SKEW_BYPASS_EN
    input  logic bypass_i,
`endif
    skew_stager_if.slave bus
);
    localparam int DATA_W = LANES * LANE_W;
    localparam int CW     = (LANES > 2) ? $clog2(LANES - 1) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_adv;
    logic              w_accept;
    logic              w_beat;
    logic              w_end;
    logic              w_byp;
    logic              w_short;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_skew;

    assign w_adv    = !r_out_valid || bus.out_ready_i;
    assign w_accept = w_adv && (r_state != DRAIN) && bus.in_valid_i;
    assign w_beat   = w_accept || (w_adv && (r_state == DRAIN));
    assign w_end    = w_accept && bus.in_last_i;
    assign w_word   = w_accept ? bus.in_data_i : '0;
    assign w_short  = (LANES == 1) || w_byp;

`ifdef SKEW_BYPASS_EN
    logic r_byp;

    // Flag is captured on the frame's first word and held to frame end.
    assign w_byp = (r_state == IDLE) ? bypass_i : r_byp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp <= 1'b0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_byp <= bypass_i;
        end
    end
`else
    assign w_byp = 1'b0;
`endif

    assign w_skew[LANE_W-1:0] = w_word[LANE_W-1:0];

    // Lane g keeps its last g lane values; the oldest sits at the top.
    for (genvar g = 1; g < LANES; g++) begin : g_lane
        logic [g*LANE_W-1:0] r_sr;

        if (g == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else if (w_beat && !w_byp) begin
                    r_sr <= w_word[g*LANE_W +: LANE_W];
                end
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else if (w_beat && !w_byp) begin
                    r_sr <= {r_sr[(g-1)*LANE_W-1:0],
                             w_word[g*LANE_W +: LANE_W]};
                end
            end
        end

        assign w_skew[g*LANE_W +: LANE_W] = r_sr[g*LANE_W-1 -: LANE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_beat) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_byp ? w_word : w_skew;
                r_out_last  <= (w_end && w_short) ||
                               ((r_state == DRAIN) && (r_cnt == '0));
            end else if (w_adv) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            unique case (r_state)
                IDLE, STREAM: begin
                    if (w_end) begin
                        if (w_short) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DRAIN;
                            r_cnt   <= CW'(LANES - 2);
                        end
                    end else if (w_accept) begin
                        r_state <= STREAM;
                    end
                end
                DRAIN: begin
                    if (w_adv) begin
                        if (r_cnt == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = w_adv && (r_state != DRAIN);
    assign bus.out_data_o  = r_out_data;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_last_o  = r_out_last;
    assign bus.busy_o      = (r_state != IDLE) || r_out_valid;
endmodule

// File: tb/tb_skew_stager.sv
// tb_skew_stager: directed frames against hand-computed wavefronts.
// Build with +define+SKEW_BYPASS_EN to include the bypass scenario.
module tb_skew_stager;
    logic clk = 1'b0;
    logic rst;
    logic bypass;

    int checks   = 0;
    int failures = 0;

    logic [15:0] q_data[$];
    logic        q_last[$];

    skew_stager_if #(.LANES(4), .LANE_W(4)) bus ();

    skew_stager #(.LANES(4), .LANE_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SKEW_BYPASS_EN
        .bypass_i (bypass),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            q_data.push_back(bus.out_data_o);
            q_last.push_back(bus.out_last_o);
        end
    end

    task automatic send_word(input logic [15:0] d, input logic l);
        int n = 0;
        bus.in_data_i  = d;
        bus.in_last_i  = l;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout word=%h never accepted", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        bus.in_data_i  = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.busy_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy_o) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout busy still 1", tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", bus.out_valid_o);
        end
        checks++;
        if (bus.out_data_o !== 16'h0000) begin
            failures++;
            $display("FAIL rst_data got=%h exp=0000", bus.out_data_o);
        end
        checks++;
        if (bus.out_last_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_last got=%b exp=0", bus.out_last_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b exp=0", bus.busy_o);
        end
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=1", bus.in_ready_o);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp [7];
        exp = '{16'h0001, 16'h0012, 16'h0123, 16'h1234,
                16'h2340, 16'h3400, 16'h4000};
        q_data.delete();
        q_last.delete();
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        wait_idle("basic");
        checks++;
        if (q_data.size() !== 7) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=7", q_data.size());
        end
        for (int i = 0; i < 7 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i]) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h exp=%h",
                         i, q_data[i], exp[i]);
            end
            checks++;
            if (q_last[i] !== (i == 6)) begin
                failures++;
                $display("FAIL basic_last%0d got=%b exp=%b",
                         i, q_last[i], i == 6);
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] exp [4];
        int nrdy = 0;
        int n    = 0;
        exp = '{16'h000D, 16'h00C0, 16'h0B00, 16'hA000};
        q_data.delete();
        q_last.delete();
        send_word(16'hABCD, 1'b1);
        @(negedge clk);
        while (bus.busy_o && n < 40) begin
            if (!bus.in_ready_o) nrdy++;
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (nrdy !== 3) begin
            failures++;
            $display("FAIL single_drain_ready0 got=%0d exp=3", nrdy);
        end
        checks++;
        if (q_data.size() !== 4) begin
            failures++;
            $display("FAIL single_count got=%0d exp=4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i] || q_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL single_beat%0d got=%h/%b exp=%h/%b",
                         i, q_data[i], q_last[i], exp[i], i == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [7];
        exp = '{16'h0001, 16'h0012, 16'h0123, 16'h1234,
                16'h2340, 16'h3400, 16'h4000};
        q_data.delete();
        q_last.delete();
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        bus.out_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 16'h0012) begin
                failures++;
                $display("FAIL bp_stream_hold got=%b/%h exp=1/0012",
                         bus.out_valid_o, bus.out_data_o);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        bus.out_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.out_data_o !== 16'h1234 || bus.in_ready_o !== 1'b0 ||
                bus.busy_o !== 1'b1) begin
                failures++;
                $display("FAIL bp_drain_hold got=%h/%b/%b exp=1234/0/1",
                         bus.out_data_o, bus.in_ready_o, bus.busy_o);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        wait_idle("bp");
        checks++;
        if (q_data.size() !== 7) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=7", q_data.size());
        end
        for (int i = 0; i < 7 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i] || q_last[i] !== (i == 6)) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b",
                         i, q_data[i], q_last[i], exp[i], i == 6);
            end
        end
    endtask

    task automatic test_gap();
        logic [15:0] exp [7];
        exp = '{16'h0001, 16'h0012, 16'h0123, 16'h1234,
                16'h2340, 16'h3400, 16'h4000};
        q_data.delete();
        q_last.delete();
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL gap_valid got=%b exp=0", bus.out_valid_o);
        end
        @(posedge clk);
        #1;
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        wait_idle("gap");
        checks++;
        if (q_data.size() !== 7) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=7", q_data.size());
        end
        for (int i = 0; i < 7 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i] || q_last[i] !== (i == 6)) begin
                failures++;
                $display("FAIL gap_beat%0d got=%h/%b exp=%h/%b",
                         i, q_data[i], q_last[i], exp[i], i == 6);
            end
        end
    endtask

    task automatic test_midreset();
        logic [15:0] exp [4];
        int nlast = 0;
        exp = '{16'h000D, 16'h00C0, 16'h0B00, 16'hA000};
        q_data.delete();
        q_last.delete();
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 16'h0000 ||
            bus.out_last_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL mrst_state got=v%b d%h l%b b%b r%b exp=v0 d0000 l0 b0 r1",
                     bus.out_valid_o, bus.out_data_o, bus.out_last_o,
                     bus.busy_o, bus.in_ready_o);
        end
        foreach (q_last[i]) if (q_last[i]) nlast++;
        checks++;
        if (nlast !== 0) begin
            failures++;
            $display("FAIL mrst_no_last got=%0d exp=0", nlast);
        end
        q_data.delete();
        q_last.delete();
        send_word(16'hABCD, 1'b1);
        wait_idle("mrst");
        checks++;
        if (q_data.size() !== 4) begin
            failures++;
            $display("FAIL mrst_count got=%0d exp=4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i] || q_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL mrst_beat%0d got=%h/%b exp=%h/%b",
                         i, q_data[i], q_last[i], exp[i], i == 3);
            end
        end
    endtask

`ifdef SKEW_BYPASS_EN
    task automatic test_bypass();
        logic [15:0] exp [4];
        exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        q_data.delete();
        q_last.delete();
        bypass = 1'b1;
        send_word(16'h1111, 1'b0);
        bypass = 1'b0;
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        wait_idle("byp");
        checks++;
        if (q_data.size() !== 4) begin
            failures++;
            $display("FAIL byp_count got=%0d exp=4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp[i] || q_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL byp_beat%0d got=%h/%b exp=%h/%b",
                         i, q_data[i], q_last[i], exp[i], i == 3);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bypass          = 1'b0;
        bus.in_data_i   = '0;
        bus.in_valid_i  = 1'b0;
        bus.in_last_i   = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_gap();
        test_midreset();
`ifdef SKEW_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
